serv_dbus_ctrl: RTL and testbench
=================================

SERV_DBUS_CTRL -- requirements
Module: serv_dbus_ctrl

Interface
REQ-001 Parameter ZERO_DAT, default 1: SHALL drive o_dbus_dat to 0 whenever o_dbus_cyc=0; if 0, o_dbus_dat SHALL show the data register at all times.
REQ-002 i_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_start  in  1  one-cycle pulse that begins a memory op; ignored unless in IDLE.
REQ-005 i_we / i_signed  in  1 / 1  store select / sign-extend loads; sampled with i_start.
REQ-006 i_size  in  2  00 byte, 01 half, 10 word, 11 treated as word; sampled with i_start.
REQ-007 i_adr  in  32  byte address from the buffer register; sampled with i_start.
REQ-008 i_en  in  1  serial-bit strobe; i_rs2  in  1  serial store data, LSB first.
REQ-009 o_rd  out  1  serial load data, LSB first; o_busy  out  1  not IDLE; o_done  out  1  one-cycle completion pulse.
REQ-010 o_misalign  out  1  one-cycle misaligned-access pulse.
REQ-011 o_dbus_adr 32, o_dbus_dat 32, o_dbus_sel 4, o_dbus_we 1, o_dbus_cyc 1  out; i_dbus_rdt 32, i_dbus_ack 1  in; Wishbone-classic data port.

Function
REQ-012 States SHALL be IDLE, SHIFT_IN, REQ, SHIFT_OUT; 5-bit bit counter, cleared on entry to SHIFT_IN and SHIFT_OUT.
REQ-013 IDLE + i_start: store -> SHIFT_IN; load -> REQ; the op is latched in the same cycle.
REQ-014 SHIFT_IN: each i_en cycle SHALL shift i_rs2 into data[31] (right shift); after the 32nd i_en cycle -> REQ.
REQ-015 REQ: o_dbus_cyc=1, o_dbus_adr={adr[31:2],2'b00}, o_dbus_we=op_we, held stable until i_dbus_ack sampled 1.
REQ-016 Store lanes: byte -> dat={4{d[7:0]}}, sel=4'b0001<<adr[1:0]; half -> dat={2{d[15:0]}}, sel=4'b0011<<{adr[1],1'b0}; word -> dat=d, sel=4'hF.
REQ-017 Loads SHALL drive sel=4'hF.
REQ-018 Ack on store: REQ -> IDLE, o_done=1 for that transition cycle, o_dbus_cyc=0 on the next cycle.
REQ-019 Ack on load: i_dbus_rdt latched, REQ -> SHIFT_OUT; o_dbus_cyc=0 on the next cycle.
REQ-020 SHIFT_OUT: o_rd=bit cnt of the extracted word (byte at adr[1:0]*8, half at adr[1]*16), bits above the width = sign bit if i_signed else 0; o_rd=0 when i_en=0; after 32nd i_en -> IDLE with o_done=1.
REQ-021 i_dbus_ack outside REQ SHALL be ignored; i_start while o_busy=1 SHALL be ignored.
REQ-022 Counter wrap 31->0 SHALL coincide with the state exit; no extra cycle.

Reset
REQ-023 i_rst SHALL force IDLE, counter=0, o_dbus_cyc=0, o_done=0, o_misalign=0, o_busy=0 on the next edge, including mid-REQ (bus cycle abandoned).
REQ-024 The data register SHALL not be reset; o_dbus_dat is undefined while cyc=0 when ZERO_DAT=0.

Configuration
REQ-025 Macro SERV_DBUS_MISALIGN_TRAP_EN defined: i_start with half and adr[0]=1, or word and adr[1:0]!=0, SHALL pulse o_misalign the following cycle, stay in IDLE, issue no bus cycle and no o_done.
REQ-026 Macro undefined: o_misalign tied 0; such accesses proceed with sel/extraction as in REQ-016/REQ-020 on the unmodified adr[1:0].

Structure
REQ-027 Shared package serv_dbus_pkg SHALL hold the state enum and the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD).
REQ-028 One sub-module serv_dbus_lane SHALL hold the combinational store replication/sel and the load extraction/extension logic.

Verification
REQ-029 Store word 0xDEADBEEF at adr 0x100, ack after 3 wait cycles -> cyc for 4 cycles, adr 0x100, sel F, dat 0xDEADBEEF, we=1, one o_done.
REQ-030 Store byte 0xA5 at adr 0x203 -> sel 4'b1000, dat 0xA5A5A5A5, adr 0x200.
REQ-031 Load byte signed at adr 0x301, rdt 0x0000_80_00 -> o_rd serial 0xFFFFFF80; unsigned -> 0x00000080.
REQ-032 Load half unsigned at adr 0x402, rdt 0xBEEF1234 -> o_rd serial 0x0000BEEF, o_done after 32nd i_en.
REQ-033 i_rst asserted during REQ with ack held low -> cyc=0 next cycle, o_busy=0, later ack ignored, no o_done.
REQ-034 With SERV_DBUS_MISALIGN_TRAP_EN, load word at 0x501 -> o_misalign one cycle, no cyc; without -> normal bus cycle to 0x500.

Source files
------------

// File: rtl/serv_dbus_pkg.sv
// serv_dbus shared types: FSM states, size codes.
// Optional trap logic uses SERV_DBUS_MISALIGN_TRAP_EN.
package serv_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_IN,
    REQ,
    SHIFT_OUT
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // size 11 behaves as a word
  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    if (sz == SZ_HALF) return lo[0];
    if (sz[1]) return lo != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/serv_dbus_lane.sv
// serv_dbus byte-lane logic: store replication/sel,
// load extraction and sign/zero extension per bit.
module serv_dbus_lane
  import serv_dbus_pkg::*;
(
  input  logic        i_we,
  input  logic        i_signed,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_dat,
  input  logic [4:0]  i_cnt,
  output logic [31:0] o_dat,
  output logic [3:0]  o_sel,
  output logic        o_rd
);

  logic [31:0] sh;
  logic [4:0]  msb;
  logic        sign;

  // lane placement for stores, right-align for loads
  always_comb begin
    o_dat = i_dat;
    o_sel = 4'hF;
    sh    = i_dat;
    msb   = 5'd31;
    unique case (1'b1)
      i_size == SZ_BYTE: begin
        o_dat = {4{i_dat[7:0]}};
        o_sel = 4'b0001 << i_lo;
        sh    = i_dat >> {i_lo, 3'b000};
        msb   = 5'd7;
      end
      i_size == SZ_HALF: begin
        o_dat = {2{i_dat[15:0]}};
        o_sel = 4'b0011 << {i_lo[1], 1'b0};
        sh    = i_dat >> {i_lo[1], 4'b0000};
        msb   = 5'd15;
      end
      default: ;
    endcase
    if (!i_we) o_sel = 4'hF;
  end

  assign sign = sh[msb];
  assign o_rd = (i_cnt > msb) ? (i_signed & sign)
                              : sh[i_cnt];

endmodule

// File: rtl/serv_dbus_ctrl.sv
// serv_dbus_ctrl: serial-to-Wishbone data bus controller.
// Define SERV_DBUS_MISALIGN_TRAP_EN to trap misaligned ops.
module serv_dbus_ctrl
  import serv_dbus_pkg::*;
#(
  parameter logic ZERO_DAT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic        i_signed,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_adr,
  input  logic        i_en,
  input  logic        i_rs2,
  output logic        o_rd,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_misalign,
  output logic [31:0] o_dbus_adr,
  output logic [31:0] o_dbus_dat,
  output logic [3:0]  o_dbus_sel,
  output logic        o_dbus_we,
  output logic        o_dbus_cyc,
  input  logic [31:0] i_dbus_rdt,
  input  logic        i_dbus_ack
);

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  cnt_q;
  logic [31:0] dat_q;
  logic [31:0] adr_q;
  logic        we_q;
  logic        sg_q;
  logic [1:0]  sz_q;
  logic        latch;
  logic        cnt_clr;
  logic        ld_rdt;
  logic        done;
  logic        trap;
  logic        shifting;
  logic [31:0] lane_dat;
  logic [3:0]  lane_sel;
  logic        lane_rd;

`ifdef SERV_DBUS_MISALIGN_TRAP_EN
  logic mis_q;

  assign trap = misaligned(i_size, i_adr[1:0]);

  // one-cycle pulse after a rejected start
  always_ff @(posedge i_clk) begin
    if (i_rst) mis_q <= 1'b0;
    else mis_q <= (state_q == IDLE) & i_start & trap;
  end

  assign o_misalign = mis_q;
`else
  assign trap       = 1'b0;
  assign o_misalign = 1'b0;
`endif

  assign shifting = (state_q == SHIFT_IN) |
                    (state_q == SHIFT_OUT);

  // next state and strobes
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    ld_rdt  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start && !trap) begin
          latch   = 1'b1;
          cnt_clr = 1'b1;
          state_d = i_we ? SHIFT_IN : REQ;
        end
      end
      SHIFT_IN: begin
        if (i_en && cnt_q == 5'd31) state_d = REQ;
      end
      REQ: begin
        if (i_dbus_ack) begin
          if (we_q) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            state_d = SHIFT_OUT;
            cnt_clr = 1'b1;
            ld_rdt  = 1'b1;
          end
        end
      end
      SHIFT_OUT: begin
        if (i_en && cnt_q == 5'd31) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and bit counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      if (cnt_clr) cnt_q <= 5'd0;
      else if (i_en && shifting) cnt_q <= cnt_q + 5'd1;
    end
  end

  // op fields and data register, never reset
  always_ff @(posedge i_clk) begin
    if (latch) begin
      we_q  <= i_we;
      sg_q  <= i_signed;
      sz_q  <= i_size;
      adr_q <= i_adr;
    end
    if (ld_rdt) dat_q <= i_dbus_rdt;
    else if (state_q == SHIFT_IN && i_en)
      dat_q <= {i_rs2, dat_q[31:1]};
  end

  serv_dbus_lane u_lane (
    .i_we     (we_q),
    .i_signed (sg_q),
    .i_size   (sz_q),
    .i_lo     (adr_q[1:0]),
    .i_dat    (dat_q),
    .i_cnt    (cnt_q),
    .o_dat    (lane_dat),
    .o_sel    (lane_sel),
    .o_rd     (lane_rd)
  );

  assign o_busy     = state_q != IDLE;
  assign o_done     = done;
  assign o_dbus_cyc = state_q == REQ;
  assign o_dbus_adr = {adr_q[31:2], 2'b00};
  assign o_dbus_we  = o_dbus_cyc & we_q;
  assign o_dbus_sel = lane_sel;
  assign o_dbus_dat = (ZERO_DAT && !o_dbus_cyc) ? 32'd0
                                                : lane_dat;
  assign o_rd       = (state_q == SHIFT_OUT) & i_en & lane_rd;

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Bench for serv_dbus_ctrl: directed table, reset
// corner case, and random ops against a reference model.
module tb_serv_dbus_ctrl;

`ifdef SERV_DBUS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_we = 1'b0;
  logic        i_signed = 1'b0;
  logic [1:0]  i_size = 2'd0;
  logic [31:0] i_adr = 32'd0;
  logic        i_en = 1'b0;
  logic        i_rs2 = 1'b0;
  logic        o_rd;
  logic        o_busy;
  logic        o_done;
  logic        o_misalign;
  logic [31:0] o_dbus_adr;
  logic [31:0] o_dbus_dat;
  logic [3:0]  o_dbus_sel;
  logic        o_dbus_we;
  logic        o_dbus_cyc;
  logic [31:0] i_dbus_rdt = 32'd0;
  logic        i_dbus_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serv_dbus_ctrl dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_we       (i_we),
    .i_signed   (i_signed),
    .i_size     (i_size),
    .i_adr      (i_adr),
    .i_en       (i_en),
    .i_rs2      (i_rs2),
    .o_rd       (o_rd),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_misalign (o_misalign),
    .o_dbus_adr (o_dbus_adr),
    .o_dbus_dat (o_dbus_dat),
    .o_dbus_sel (o_dbus_sel),
    .o_dbus_we  (o_dbus_we),
    .o_dbus_cyc (o_dbus_cyc),
    .i_dbus_rdt (i_dbus_rdt),
    .i_dbus_ack (i_dbus_ack)
  );

  typedef struct {
    logic        we;
    logic        sg;
    logic [1:0]  sz;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdt;
    int          waits;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_val;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic m_trap(input logic [1:0] sz,
                                  input logic [31:0] adr);
    if (!TRAP) return 1'b0;
    if (sz == 2'd1) return (adr % 2) != 0;
    if (sz >= 2'd2) return (adr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_sel(input logic we,
                                       input logic [1:0] sz,
                                       input logic [31:0] adr);
    if (!we) return 4'hF;
    if (sz == 2'd0) return 4'(1 << (adr % 4));
    if (sz == 2'd1) return 4'(3 << ((adr % 4) / 2 * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_sdat(input logic [1:0] sz,
                                         input logic [31:0] wd);
    if (sz == 2'd0) return (wd % 256) * 32'h01010101;
    if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz,
                                         input logic sg,
                                         input logic [31:0] adr,
                                         input logic [31:0] rdt);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rdt >> (8 * (adr % 4))) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (rdt >> (16 * ((adr / 2) % 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = rdt;
    end
    return v;
  endfunction

  task automatic run_op(input logic we,
                        input logic sg,
                        input logic [1:0] sz,
                        input logic [31:0] adr,
                        input logic [31:0] wd,
                        input logic [31:0] rdt,
                        input int waits,
                        output logic trapped,
                        output logic [31:0] rd_ser,
                        output logic [31:0] b_adr,
                        output logic [31:0] b_dat,
                        output logic [3:0] b_sel,
                        output logic b_we,
                        output int ncyc,
                        output int ndone);
    int i;
    rd_ser = 0; b_adr = 0; b_dat = 0;
    b_sel = 0; b_we = 0; ncyc = 0; ndone = 0;
    i_dbus_rdt = rdt;
    i_start = 1'b1; i_we = we; i_signed = sg;
    i_size = sz; i_adr = adr;
    #1 ndone += int'(o_done);
    @(negedge clk);
    i_start = 1'b0;
    i_we = 1'($urandom);
    i_signed = 1'($urandom);
    i_size = 2'($urandom_range(0, 3));
    i_adr = $urandom;
    #1 trapped = o_misalign;
    if (trapped) begin
      chk("trap_busy", 32'(o_busy), 32'd0);
      chk("trap_cyc", 32'(o_dbus_cyc), 32'd0);
      @(negedge clk);
      #1 chk("trap_pulse_end", 32'(o_misalign), 32'd0);
      chk("trap_cyc2", 32'(o_dbus_cyc), 32'd0);
      ndone += int'(o_done);
      @(negedge clk);
      return;
    end
    if (we) begin
      i = 0;
      for (int c = 0; c < 200 && i < 32; c++) begin
        i_en = ($urandom_range(0, 3) != 0);
        i_rs2 = wd[i];
        i_start = ($urandom_range(0, 7) == 0);
        i_dbus_ack = 1'($urandom);
        #1 ndone += int'(o_done);
        ncyc += int'(o_dbus_cyc);
        if (i_en) i++;
        @(negedge clk);
      end
      i_en = 1'b0;
    end
    for (int k = 0; k <= waits; k++) begin
      i_dbus_ack = (k == waits);
      i_start = ($urandom_range(0, 3) == 0);
      #1;
      if (o_dbus_cyc) begin
        ncyc++;
        b_adr = o_dbus_adr; b_dat = o_dbus_dat;
        b_sel = o_dbus_sel; b_we = o_dbus_we;
      end
      ndone += int'(o_done);
      if (we && k == waits)
        chk("st_done", 32'(o_done), 32'd1);
      @(negedge clk);
    end
    i_dbus_ack = 1'b0;
    i_start = 1'b0;
    if (!we) begin
      i = 0;
      for (int c = 0; c < 200 && i < 32; c++) begin
        i_en = ($urandom_range(0, 3) != 0);
        i_start = ($urandom_range(0, 7) == 0);
        i_dbus_ack = 1'($urandom);
        #1;
        if (i_en) begin
          rd_ser[i] = o_rd;
          if (i == 31)
            chk("ld_done", 32'(o_done), 32'd1);
          i++;
        end else begin
          chk("rd_idle", 32'(o_rd), 32'd0);
        end
        ndone += int'(o_done);
        ncyc += int'(o_dbus_cyc);
        @(negedge clk);
      end
      i_en = 1'b0; i_start = 1'b0; i_dbus_ack = 1'b0;
    end
    #1 chk("end_busy", 32'(o_busy), 32'd0);
    chk("end_cyc", 32'(o_dbus_cyc), 32'd0);
    chk("idle_dat", o_dbus_dat, 32'd0);
    ndone += int'(o_done);
    @(negedge clk);
  endtask

  task automatic check_op(input string tag,
                          input vec_t v);
    logic trp;
    logic [31:0] rd, ba, bd;
    logic [3:0] bs;
    logic bw;
    int nc, nd;
    logic et;
    et = m_trap(v.sz, v.adr);
    run_op(v.we, v.sg, v.sz, v.adr, v.wd, v.rdt,
           v.waits, trp, rd, ba, bd, bs, bw, nc, nd);
    chk({tag, "_trap"}, 32'(trp), 32'(et));
    if (et) begin
      chk({tag, "_ncyc"}, nc, 0);
      chk({tag, "_ndone"}, nd, 0);
    end else begin
      chk({tag, "_adr"}, ba, v.e_adr);
      chk({tag, "_sel"}, 32'(bs), 32'(v.e_sel));
      chk({tag, "_we"}, 32'(bw), 32'(v.we));
      chk({tag, "_ncyc"}, nc, v.waits + 1);
      chk({tag, "_ndone"}, nd, 1);
      if (v.we) chk({tag, "_dat"}, bd, v.e_val);
      else chk({tag, "_rd"}, rd, v.e_val);
    end
  endtask

  vec_t tbl[9];

  initial begin
    int nd, nc;
    vec_t r;
    tbl[0] = '{1, 0, 2'd2, 32'h100, 32'hDEADBEEF, 0, 3,
               32'h100, 4'hF, 32'hDEADBEEF};
    tbl[1] = '{1, 0, 2'd0, 32'h203, 32'h123456A5, 0, 1,
               32'h200, 4'b1000, 32'hA5A5A5A5};
    tbl[2] = '{0, 1, 2'd0, 32'h301, 0, 32'h00008000, 0,
               32'h300, 4'hF, 32'hFFFFFF80};
    tbl[3] = '{0, 0, 2'd0, 32'h301, 0, 32'h00008000, 2,
               32'h300, 4'hF, 32'h00000080};
    tbl[4] = '{0, 0, 2'd1, 32'h402, 0, 32'hBEEF1234, 1,
               32'h400, 4'hF, 32'h0000BEEF};
    tbl[5] = '{0, 0, 2'd2, 32'h501, 0, 32'h13579BDF, 0,
               32'h500, 4'hF, 32'h13579BDF};
    tbl[6] = '{1, 0, 2'd1, 32'h602, 32'h1111C0DE, 0, 2,
               32'h600, 4'b1100, 32'hC0DEC0DE};
    tbl[7] = '{0, 1, 2'd1, 32'h700, 0, 32'h12348001, 0,
               32'h700, 4'hF, 32'hFFFF8001};
    tbl[8] = '{0, 1, 2'd3, 32'h804, 0, 32'hAABBCCDD, 4,
               32'h804, 4'hF, 32'hAABBCCDD};

    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    #1 chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_cyc", 32'(o_dbus_cyc), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_mis", 32'(o_misalign), 32'd0);
    chk("rst_dat", o_dbus_dat, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      check_op($sformatf("v%0d", i), tbl[i]);

    // reset while a load waits for ack
    i_start = 1'b1; i_we = 1'b0; i_size = 2'd2;
    i_adr = 32'h900;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    #1 chk("rreq_cyc", 32'(o_dbus_cyc), 32'd1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    #1 chk("rreq_cyc0", 32'(o_dbus_cyc), 32'd0);
    chk("rreq_busy", 32'(o_busy), 32'd0);
    chk("rreq_done", 32'(o_done), 32'd0);
    i_dbus_ack = 1'b1;
    nd = 0; nc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 nd += int'(o_done);
      nc += int'(o_dbus_cyc) + int'(o_busy);
    end
    i_dbus_ack = 1'b0;
    chk("rreq_late_done", nd, 0);
    chk("rreq_late_act", nc, 0);
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      r.we = 1'($urandom);
      r.sg = 1'($urandom);
      r.sz = 2'($urandom_range(0, 3));
      r.adr = $urandom;
      r.wd = $urandom;
      r.rdt = $urandom;
      r.waits = $urandom_range(0, 4);
      r.e_adr = r.adr & 32'hFFFFFFFC;
      r.e_sel = m_sel(r.we, r.sz, r.adr);
      r.e_val = r.we ? m_sdat(r.sz, r.wd)
                     : m_load(r.sz, r.sg, r.adr, r.rdt);
      check_op($sformatf("r%0d", n), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
